// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_lane_extract.sv
// Load alignment: picks the addressed byte/half out of a RAM word and extends it.
module dmem_lane_extract (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_hb,
    input  logic        i_uload,
    output logic [31:0] o_data
);
    import dmem_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        case (i_hb)
            HB_BYTE: o_data = {{24{w_byte[7] & ~i_uload}}, w_byte};
            HB_HALF: o_data = {{16{w_half[15] & ~i_uload}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: handshaked load/store port in front of a word RAM,
// with wait states, byte-lane stores and aligned/extended load returns.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_REQ,
    output logic        o_READY,
    input  logic        i_WE,
    input  logic        i_RE,
    input  logic [1:0]  i_HB,
    input  logic        i_ULOAD,
    input  logic [31:0] i_ADDR,
    input  logic [31:0] i_WDATA,
    output logic        o_RVALID,
    output logic [31:0] o_RDATA,
    output logic        o_ERR
);
    import dmem_pkg::*;

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

    state_e             r_state;
    logic               r_ready;
    logic               r_rvalid;
    logic [CNT_W-1:0]   r_cnt;

    logic [AW+1:0]      r_addr;
    logic [1:0]         r_hb;
    logic               r_uload;
    logic               r_we;
    logic               r_re;
    logic               r_err;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rword;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_req_err;
    logic               w_access;
    logic [AW-1:0]      w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_ext;

    function automatic logic [3:0] lane_mask(input logic [1:0] hb, input logic [1:0] a);
        case (hb)
            HB_BYTE: return 4'b0001 << a;
            HB_HALF: return a[1] ? 4'b1100 : 4'b0011;
            HB_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] hb, input logic [31:0] d);
        case (hb)
            HB_BYTE: return {4{d[7:0]}};
            HB_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign w_accept  = i_REQ && r_ready && !i_RST;
    assign w_req_err = (i_HB == 2'b11)
                     | ((i_HB == HB_HALF) && i_ADDR[0])
                     | ((i_HB == HB_WORD) && (i_ADDR[1:0] != 2'b00))
                     | (i_ADDR[31:2] >= DEPTH_L)
                     | (i_WE == i_RE);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(WAIT_STATES)) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_rvalid <= 1'b1;
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_rvalid <= 1'b0;
                    r_ready  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are captured once at accept and held for the whole transaction.
    always_ff @(posedge i_CLK) begin
        if (w_accept) begin
            r_addr  <= i_ADDR[AW+1:0];
            r_hb    <= i_HB;
            r_uload <= i_ULOAD;
            r_we    <= i_WE;
            r_re    <= i_RE;
            r_wdata <= i_WDATA;
            r_err   <= w_req_err;
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_idx    = r_addr[AW+1:2];
    assign w_be     = lane_mask(r_hb, r_addr[1:0]);
    assign w_wdata  = lane_data(r_hb, r_wdata);

    always_ff @(posedge i_CLK) begin
        if (w_access) begin
            if (r_we && !r_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
            r_rword <= r_mem[w_idx];
        end
    end

    dmem_lane_extract u_extract (
        .i_word    (r_rword),
        .i_addr_lo (r_addr[1:0]),
        .i_hb      (r_hb),
        .i_uload   (r_uload),
        .o_data    (w_ext)
    );

    // Data is only driven for a clean load; stores and errors return zero.
    assign o_READY  = r_ready;
    assign o_RVALID = r_rvalid;
    assign o_ERR    = r_rvalid && r_err;
    assign o_RDATA  = (r_rvalid && r_re && !r_we && !r_err) ? w_ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, directed and random traffic.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS_A  = 1;
    localparam int WS_B  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          nvec = 0;
    int          nbad = 0;

    logic        a_req = 0, a_we = 0, a_re = 0, a_ul = 0;
    logic [1:0]  a_hb = 0;
    logic [31:0] a_addr = 0, a_wd = 0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;

    logic        b_req = 0, b_we = 0, b_re = 0, b_ul = 0;
    logic [1:0]  b_hb = 0;
    logic [31:0] b_addr = 0, b_wd = 0;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_ref [DEPTH*4];
    logic        prev_rv = 1'b0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A), .CNT_W(4)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_REQ(a_req), .o_READY(a_ready),
        .i_WE(a_we), .i_RE(a_re), .i_HB(a_hb), .i_ULOAD(a_ul),
        .i_ADDR(a_addr), .i_WDATA(a_wd),
        .o_RVALID(a_rvalid), .o_RDATA(a_rdata), .o_ERR(a_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B), .CNT_W(4)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_REQ(b_req), .o_READY(b_ready),
        .i_WE(b_we), .i_RE(b_re), .i_HB(b_hb), .i_ULOAD(b_ul),
        .i_ADDR(b_addr), .i_WDATA(b_wd),
        .o_RVALID(b_rvalid), .o_RDATA(b_rdata), .o_ERR(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory as a flat byte array, access of 2**hb bytes starting at addr.
    function automatic void model(input logic we, input logic re, input logic [1:0] hb,
                                  input logic ul, input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n;
        logic [63:0] v;
        err = (hb == 2'b11) || (hb == 2'b01 && addr[0]) || (hb == 2'b10 && addr[1:0] != 2'b00)
              || (addr >= 32'(DEPTH*4)) || (we == re);
        rd = 32'd0;
        if (err) return;
        n = 1 << hb;
        if (we) begin
            for (int i = 0; i < n; i++) mem_ref[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = v | (64'(mem_ref[int'(addr) + i]) << (8*i));
            if (!ul && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            rd = v[31:0];
        end
    endfunction

    task automatic wait_ready_a();
        int n = 0;
        while (a_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (a_ready !== 1'b1) chk("a_ready_timeout", {31'd0, a_ready}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic re, input logic [1:0] hb, input logic ul,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic use_c, input logic [31:0] c_rd, input logic c_err);
        logic [31:0] m_rd;
        logic        m_err;
        exp_t        e;
        wait_ready_a();
        a_we = we; a_re = re; a_hb = hb; a_ul = ul; a_addr = addr; a_wd = wd; a_req = 1'b1;
        @(negedge clk);
        model(we, re, hb, ul, addr, wd, m_rd, m_err);
        e.rd  = use_c ? c_rd : m_rd;
        e.err = use_c ? c_err : m_err;
        e.due = cyc + WS_A + 1;
        q.push_back(e);
        a_req = 1'b0;
        chk("ready_low_after_accept", {31'd0, a_ready}, 32'd0);
    endtask

    // Monitor: pops one expectation per response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (prev_rv) begin
            chk("strobe_one_cycle", {30'd0, a_rvalid, a_ready}, 32'd1);
        end
        if (a_rvalid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rdata", a_rdata, e.rd);
                chk("err", {31'd0, a_err}, {31'd0, e.err});
                chk("latency", 32'(cyc), 32'(e.due));
                chk("ready_low_in_resp", {31'd0, a_ready}, 32'd0);
            end
        end
        prev_rv = (a_rvalid === 1'b1);
    end

    initial begin
        int nrv;
        int n;
        logic        r_we, r_re, r_ul;
        logic [1:0]  r_hb;
        logic [31:0] r_addr;

        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, a_ready}, 32'd1);
        chk("reset_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("reset_rdata", a_rdata, 32'd0);
        chk("reset_err", {31'd0, a_err}, 32'd0);
        chk("reset_ready_b", {31'd0, b_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic word store/load, then sub-word loads of the same word.
        issue(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
        issue(0, 1, 2'b00, 0, 32'h11, 32'h0, 1, 32'hFFFFFFBE, 0);
        issue(0, 1, 2'b00, 1, 32'h11, 32'h0, 1, 32'h000000BE, 0);
        issue(0, 1, 2'b01, 0, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 0);
        issue(0, 1, 2'b01, 1, 32'h12, 32'h0, 1, 32'h0000DEAD, 0);
        issue(0, 1, 2'b00, 0, 32'h13, 32'h0, 1, 32'hFFFFFFDE, 0);
        // Lane-masked stores.
        issue(1, 0, 2'b00, 0, 32'h13, 32'h00000055, 1, 32'h0, 0);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h55ADBEEF, 0);
        issue(1, 0, 2'b01, 0, 32'h10, 32'h00001234, 1, 32'h0, 0);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h55AD1234, 0);
        // Error cases.
        issue(0, 1, 2'b01, 0, 32'h11, 32'h0, 1, 32'h0, 1);
        issue(1, 0, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 1, 32'h0, 1);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h55AD1234, 0);
        issue(0, 1, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 2'b10, 0, 32'(DEPTH*4), 32'h0, 1, 32'h0, 1);
        issue(1, 1, 2'b10, 0, 32'h10, 32'h12345678, 1, 32'h0, 1);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h0, 1);
        issue(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h55AD1234, 0);

        // Reset during WAIT discards the store and produces no response.
        issue(1, 0, 2'b10, 0, 32'h20, 32'h11111111, 1, 32'h0, 0);
        wait_ready_a();
        a_we = 1; a_re = 0; a_hb = 2'b10; a_addr = 32'h20; a_wd = 32'h22222222; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ready_immediate", {31'd0, a_ready}, 32'd1);
        chk("rst_no_rvalid", {31'd0, a_rvalid}, 32'd0);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(0, 1, 2'b10, 0, 32'h20, 32'h0, 1, 32'h11111111, 0);

        // Fill a small region so random loads read defined data.
        for (int w = 0; w < 64; w++) issue(1, 0, 2'b10, 0, 32'(w*4), $urandom, 0, 32'h0, 0);

        for (int t = 0; t < 250; t++) begin
            r_we = 1'($urandom_range(0, 1));
            r_re = ($urandom_range(0, 9) == 0) ? r_we : !r_we;
            r_hb = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_ul = 1'($urandom_range(0, 1));
            r_addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) r_addr = 32'(DEPTH*4) + 32'($urandom_range(0, 5000));
            if ($urandom_range(0, 49) == 0) r_addr = 32'hFFFFFFFC;
            issue(r_we, r_re, r_hb, r_ul, r_addr, $urandom, 0, 32'h0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_ready_a();
        repeat (4) @(negedge clk);

        // Three wait states, request held high: one response at E0+4, ready back at E0+5.
        n = 0;
        while (b_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        b_we = 1; b_re = 0; b_hb = 2'b10; b_ul = 0; b_addr = 32'h20; b_wd = 32'hCAFEF00D; b_req = 1'b1;
        nrv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_rvalid === 1'b1) nrv++;
            if (k <= 4) begin
                chk("b_ready_low", {31'd0, b_ready}, 32'd0);
                chk("b_rvalid_slot", {31'd0, b_rvalid}, (k == 4) ? 32'd1 : 32'd0);
            end
            if (k == 4) chk("b_store_rdata", b_rdata, 32'd0);
            if (k == 5) chk("b_ready_back", {31'd0, b_ready}, 32'd1);
        end
        b_req = 1'b0;
        chk("b_single_response", 32'(nrv), 32'd1);
        n = 0;
        while (b_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("b_idle", {31'd0, b_ready}, 32'd1);
        b_we = 0; b_re = 1; b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
        n = 0;
        while (b_rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("b_load_seen", {31'd0, b_rvalid}, 32'd1);
        chk("b_load_rdata", b_rdata, 32'hCAFEF00D);
        chk("b_load_err", {31'd0, b_err}, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
